// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module      : music_pkg
// Description : Shared types and constants for the music score transmitter:
//               FSM state encoding, duration-code hold times, and score ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

   // Sequencer states; three bits cover the five states with room to spare
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_TX = 3'd3,
      ST_HOLD    = 3'd4
   } state_t;

   // Hold times in milliseconds selected by the 3-bit duration code
   localparam int unsigned DUR_200  = 200;
   localparam int unsigned DUR_500  = 500;
   localparam int unsigned DUR_1000 = 1000;
   localparam int unsigned DUR_2000 = 2000;
   localparam int unsigned DUR_4000 = 4000;

   localparam int SCORE_LEN_DEFAULT = 96;
   localparam int SCORE_ROM_DEPTH   = 128;

   // Score entries are {tone[4:0], dur[2:0]}; only the first SCORE_LEN are played
   localparam logic [7:0] SCORE_ROM [SCORE_ROM_DEPTH] = '{
      8'h31, 8'h42, 8'h55, 8'h1F, 8'h31, 8'h01, 8'h39, 8'h43,
      8'h4A, 8'h52, 8'h29, 8'h33, 8'h3A, 8'h41, 8'h00, 8'h4B,
      8'h5C, 8'h62, 8'h31, 8'h39, 8'h42, 8'h4A, 8'h53, 8'h01,
      8'h6A, 8'h5B, 8'h49, 8'h42, 8'h3A, 8'h31, 8'h2C, 8'h11,
      8'h31, 8'h31, 8'h3A, 8'h42, 8'h4B, 8'h53, 8'h5A, 8'h01,
      8'h62, 8'h69, 8'h72, 8'h6B, 8'h62, 8'h5A, 8'h52, 8'h09,
      8'h4A, 8'h42, 8'h39, 8'h31, 8'h29, 8'h22, 8'h1A, 8'h01,
      8'h12, 8'h1A, 8'h22, 8'h2A, 8'h33, 8'h3C, 8'h44, 8'h0B,
      8'h39, 8'h41, 8'h49, 8'h51, 8'h5A, 8'h63, 8'h6C, 8'h01,
      8'h7A, 8'h72, 8'h6A, 8'h62, 8'h5A, 8'h52, 8'h4A, 8'h13,
      8'h31, 8'h42, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h01,
      8'h6A, 8'h5A, 8'h4A, 8'h3A, 8'h2A, 8'h1A, 8'h0A, 8'h05,
      8'h31, 8'h39, 8'h41, 8'h49, 8'h51, 8'h59, 8'h61, 8'h69,
      8'h71, 8'h79, 8'h81, 8'h89, 8'h91, 8'h99, 8'hA1, 8'hA9,
      8'hB1, 8'hB9, 8'hC1, 8'hC9, 8'hD1, 8'hD9, 8'hE1, 8'hE9,
      8'hF1, 8'hF9, 8'hF2, 8'hEA, 8'hE2, 8'hDA, 8'hD2, 8'h01
   };

   // Map a duration code onto its hold time in ms; unused codes fall back to 200 ms
   function automatic int unsigned dur_ms(input logic [2:0] code);
      case (code)
         3'd1:    dur_ms = DUR_200;
         3'd2:    dur_ms = DUR_500;
         3'd3:    dur_ms = DUR_1000;
         3'd4:    dur_ms = DUR_2000;
         3'd5:    dur_ms = DUR_4000;
         default: dur_ms = DUR_200;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/music_uart_tx_bit.sv
`default_nettype none
// ============================================================================
// Module      : music_uart_tx_bit
// Description : 8N1 UART serializer. A one-cycle tx_start latches tx_data and
//               sends start bit, eight data bits LSB first, and a stop bit,
//               each lasting BPS_CNT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module music_uart_tx_bit #(
   parameter int BPS_CNT = 434
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       uart_txd
);

   localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CNT_W-1:0] BPS_LAST = CNT_W'(BPS_CNT - 1);

   logic             busy_q,    busy_d;
   logic             txd_q,     txd_d;
   logic [CNT_W-1:0] bps_cnt_q, bps_cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       data_q,    data_d;

   // Bit sequencing: bit_cnt 0 is the start bit, 1..8 data, 9 the stop bit
   always_comb begin
      busy_d    = busy_q;
      txd_d     = txd_q;
      bps_cnt_d = bps_cnt_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      if (!busy_q) begin
         if (tx_start) begin
            busy_d    = 1'b1;
            txd_d     = 1'b0;
            data_d    = tx_data;
            bps_cnt_d = '0;
            bit_cnt_d = 4'd0;
         end
      end else if (bps_cnt_q == BPS_LAST) begin
         bps_cnt_d = '0;
         if (bit_cnt_q == 4'd9) begin
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
            txd_d     = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            txd_d     = (bit_cnt_q == 4'd8) ? 1'b1 : data_q[bit_cnt_q[2:0]];
         end
      end else begin
         bps_cnt_d = bps_cnt_q + 1'b1;
      end
   end

   // Serializer state registers; the line idles high out of reset
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         busy_q    <= 1'b0;
         txd_q     <= 1'b1;
         bps_cnt_q <= '0;
         bit_cnt_q <= 4'd0;
         data_q    <= 8'd0;
      end else begin
         busy_q    <= busy_d;
         txd_q     <= txd_d;
         bps_cnt_q <= bps_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
      end
   end

   assign tx_busy  = busy_q;
   assign uart_txd = txd_q;

endmodule
`default_nettype wire

// File: rtl/music_score_tx.sv
`default_nettype none
// ============================================================================
// Module      : music_score_tx
// Description : Score sequencer. Walks the score ROM, sends each entry over
//               the UART, drives the current tone and holds it for the
//               encoded duration before moving to the next note.
// Revision    : 1.0 - initial release
// ============================================================================
module music_score_tx
   import music_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int UART_BPS  = 115200,
   parameter int SCORE_LEN = SCORE_LEN_DEFAULT
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       play_en,
   output logic       uart_txd,
   output logic [4:0] music_tone,
   output logic [6:0] note_idx,
   output logic       busy
);

   localparam int          BPS_CNT    = CLK_FREQ / UART_BPS;
   localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
   localparam logic [6:0]  IDX_LAST   = 7'(SCORE_LEN - 1);

   state_t      state_q,    state_d;
   logic [1:0]  sync_q,     sync_d;
   logic [7:0]  byte_q,     byte_d;
   logic [4:0]  tone_q,     tone_d;
   logic [6:0]  idx_q,      idx_d;
   logic [27:0] hold_cnt_q, hold_cnt_d;

   logic        play_s;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  rom_byte;
   logic [6:0]  next_idx;
   logic [27:0] hold_load;

   assign play_s    = sync_q[1];
   assign rom_byte  = SCORE_ROM[idx_q];
   assign next_idx  = (idx_q == IDX_LAST) ? 7'd0 : idx_q + 7'd1;
   assign hold_load = 28'(dur_ms(byte_q[2:0]) * CYC_PER_MS - 1);
   assign sync_d    = {sync_q[0], play_en};

   // Next-state and datapath updates for the note sequencer
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      tone_d     = tone_q;
      idx_d      = idx_q;
      hold_cnt_d = hold_cnt_q;
      tx_start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (play_s) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // Tone goes out on the same edge that raises tx_start
            byte_d  = rom_byte;
            tone_d  = rom_byte[7:3];
            state_d = ST_SEND;
         end
         ST_SEND: begin
            tx_start = 1'b1;
            state_d  = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            // A started frame always completes; stop requests are honoured here
            if (!tx_busy) begin
               if (!play_s) begin
                  state_d = ST_IDLE;
                  tone_d  = 5'd0;
               end else begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = hold_load;
               end
            end
         end
         ST_HOLD: begin
            if (!play_s || hold_cnt_q == 28'd0) begin
               idx_d      = next_idx;
               hold_cnt_d = 28'd0;
               if (play_s) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  tone_d  = 5'd0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q - 28'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tone_d  = 5'd0;
         end
      endcase
   end

   // State, synchroniser and datapath registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         sync_q     <= 2'b00;
         byte_q     <= 8'd0;
         tone_q     <= 5'd0;
         idx_q      <= 7'd0;
         hold_cnt_q <= 28'd0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         byte_q     <= byte_d;
         tone_q     <= tone_d;
         idx_q      <= idx_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   music_uart_tx_bit #(
      .BPS_CNT (BPS_CNT)
   ) u_uart_tx (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tx_start  (tx_start),
      .tx_data   (byte_q),
      .tx_busy   (tx_busy),
      .uart_txd  (uart_txd)
   );

   assign music_tone = tone_q;
   assign note_idx   = idx_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
